// File: rtl/parity_frame_checker.sv
// rtl/parity_frame_checker.sv - serial frame receiver with parity check and saturating error counter
module parity_frame_checker #(
  parameter int DATA_BITS = 8,
  parameter int ODD       = 0,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 x_valid,
  input  logic                 x,
  input  logic                 clr_cnt,
  output logic                 z,
  output logic                 busy,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 frame_valid,
  output logic                 parity_err,
  output logic [CNT_W-1:0]     err_count
);

  localparam int              BW       = $clog2(DATA_BITS);
  localparam logic [BW-1:0]   LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic            ODD_BIT  = (ODD != 0);

  typedef enum logic {
    S_DATA = 1'b0,
    S_PAR  = 1'b1
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   take_data;
  logic                   take_par;
  logic                   par_bad;
  logic [BW-1:0]          bit_cnt;
  logic                   acc;
  logic [DATA_BITS-1:0]   shreg;

  // Parity bit disagrees with the running XOR (inverted for odd parity)
  assign par_bad = x ^ acc ^ ODD_BIT;
  assign z       = acc;
  assign busy    = (bit_cnt != '0) || (state == S_PAR);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_DATA;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and per-edge accept strobes; nothing moves without x_valid
  always_comb begin
    state_nxt = state;
    take_data = 1'b0;
    take_par  = 1'b0;
    if (x_valid) begin
      case (state)
        S_DATA: begin
          take_data = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state_nxt = S_PAR;
          end
        end
        S_PAR: begin
          take_par  = 1'b1;
          state_nxt = S_DATA;
        end
        default: state_nxt = S_DATA;
      endcase
    end
  end

  // Data path: shift register, running parity and the completed-frame result
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt     <= '0;
      acc         <= 1'b0;
      shreg       <= '0;
      data_out    <= '0;
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      parity_err  <= 1'b0;
      if (take_data) begin
        shreg[bit_cnt] <= x;
        acc            <= acc ^ x;
        // Counter wraps to 0 on the last data bit; the PAR state keeps busy high
        bit_cnt        <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
      end
      if (take_par) begin
        data_out    <= shreg;
        parity_err  <= par_bad;
        frame_valid <= 1'b1;
        acc         <= 1'b0;
        bit_cnt     <= '0;
      end
    end
  end

  // Saturating error counter; a clear wins over a simultaneous error
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (clr_cnt) begin
      err_count <= '0;
    end else if (take_par && par_bad && (err_count != CNT_MAX)) begin
      err_count <= err_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// tb/tb_parity_frame_checker.sv - directed self-checking bench for parity_frame_checker
module tb_parity_frame_checker;

  logic clk = 1'b0;
  logic rst;
  logic xv  [3];
  logic xb  [3];
  logic clr [3];

  logic       z_e, busy_e, fv_e, pe_e;
  logic [7:0] do_e, ec_e;
  logic       z_o, busy_o, fv_o, pe_o;
  logic [7:0] do_o, ec_o;
  logic       z_c, busy_c, fv_c, pe_c;
  logic [7:0] do_c;
  logic [1:0] ec_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parity_frame_checker u_even (
    .clk(clk), .rst(rst), .x_valid(xv[0]), .x(xb[0]), .clr_cnt(clr[0]),
    .z(z_e), .busy(busy_e), .data_out(do_e), .frame_valid(fv_e),
    .parity_err(pe_e), .err_count(ec_e)
  );

  parity_frame_checker #(.ODD(1)) u_odd (
    .clk(clk), .rst(rst), .x_valid(xv[1]), .x(xb[1]), .clr_cnt(clr[1]),
    .z(z_o), .busy(busy_o), .data_out(do_o), .frame_valid(fv_o),
    .parity_err(pe_o), .err_count(ec_o)
  );

  parity_frame_checker #(.CNT_W(2)) u_cnt2 (
    .clk(clk), .rst(rst), .x_valid(xv[2]), .x(xb[2]), .clr_cnt(clr[2]),
    .z(z_c), .busy(busy_c), .data_out(do_c), .frame_valid(fv_c),
    .parity_err(pe_c), .err_count(ec_c)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input int sel, input logic b);
    xv[sel] = 1'b1;
    xb[sel] = b;
    @(posedge clk);
    #1;
    xv[sel] = 1'b0;
    xb[sel] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_data(input int sel, input logic [7:0] d);
    for (int i = 0; i < 8; i++) send_bit(sel, d[i]);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      xv[i] = 1'b0; xb[i] = 1'b0; clr[i] = 1'b0;
    end
    rst = 1'b1;
    idle(2);
    rst = 1'b0;

    // reset state
    chk("rst_busy", busy_e, 0);
    chk("rst_z", z_e, 0);
    chk("rst_data_out", do_e, 0);
    chk("rst_frame_valid", fv_e, 0);
    chk("rst_parity_err", pe_e, 0);
    chk("rst_err_count", ec_e, 0);

    // even parity, 0xA5 good parity
    send_data(0, 8'hA5);
    chk("a5_z_after_8", z_e, 0);
    chk("a5_busy_in_par", busy_e, 1);
    send_bit(0, 1'b0);
    chk("a5_fv", fv_e, 1);
    chk("a5_data", do_e, 8'hA5);
    chk("a5_perr", pe_e, 0);
    chk("a5_errcnt", ec_e, 0);
    chk("a5_busy_done", busy_e, 0);
    idle(1);
    chk("a5_fv_pulse", fv_e, 0);
    chk("a5_data_hold", do_e, 8'hA5);

    // even parity, 0xA5 bad parity
    send_data(0, 8'hA5);
    send_bit(0, 1'b1);
    chk("a5bad_fv", fv_e, 1);
    chk("a5bad_perr", pe_e, 1);
    chk("a5bad_data", do_e, 8'hA5);
    chk("a5bad_errcnt", ec_e, 1);
    idle(1);
    chk("a5bad_perr_clears", pe_e, 0);

    // odd parity, 0x01
    send_data(1, 8'h01);
    send_bit(1, 1'b0);
    chk("odd01_fv", fv_o, 1);
    chk("odd01_perr_good", pe_o, 0);
    chk("odd01_data", do_o, 8'h01);
    send_data(1, 8'h01);
    send_bit(1, 1'b1);
    chk("odd01_perr_bad", pe_o, 1);
    chk("odd01_errcnt", ec_o, 1);

    // even parity, 0x3C with random gaps between bits
    begin
      logic [7:0] d;
      int g;
      d = 8'h3C;
      for (int i = 0; i < 8; i++) begin
        send_bit(0, d[i]);
        if (i == 2) chk("gap_z_mid", z_e, 1);
        g = $urandom_range(0, 5);
        for (int k = 0; k < g; k++) begin
          idle(1);
          chk("gap_busy", busy_e, 1);
        end
      end
      send_bit(0, 1'b0);
      chk("gap_fv", fv_e, 1);
      chk("gap_data", do_e, 8'h3C);
      chk("gap_perr", pe_e, 0);
      chk("gap_errcnt", ec_e, 1);
    end

    // CNT_W=2 saturation and clear priority
    begin
      logic [1:0] exp_seq [5];
      exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3;
      exp_seq[3] = 2'd3; exp_seq[4] = 2'd3;
      for (int f = 0; f < 5; f++) begin
        send_data(2, 8'hA5);
        send_bit(2, 1'b1);
        chk($sformatf("sat_errcnt_%0d", f), ec_c, exp_seq[f]);
      end
      send_data(2, 8'hA5);
      clr[2] = 1'b1;
      send_bit(2, 1'b1);
      clr[2] = 1'b0;
      chk("clr_wins_errcnt", ec_c, 0);
      chk("clr_perr", pe_c, 1);
      chk("clr_data", do_c, 8'hA5);
    end

    // reset mid-frame, then full 0xFF frame
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    chk("mid_z", z_e, 1);
    chk("mid_busy", busy_e, 1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("mid_rst_busy", busy_e, 0);
    chk("mid_rst_z", z_e, 0);
    chk("mid_rst_errcnt", ec_e, 0);
    send_data(0, 8'hFF);
    send_bit(0, 1'b0);
    chk("ff_fv", fv_e, 1);
    chk("ff_data", do_e, 8'hFF);
    chk("ff_perr", pe_e, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 Parameter DATA_BITS, default 8, data bits per frame; legal range 2..32.
REQ-002 Parameter ODD, default 0: 0 means even parity, 1 means odd parity.
REQ-003 Parameter CNT_W, default 8, width of the error counter; legal range 1..16.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 x_valid  input  1  qualifies x; a bit SHALL be consumed only on edges where x_valid=1.
REQ-007 x  input  1  serial bit stream; DATA_BITS data bits LSB first, then one parity bit.
REQ-008 clr_cnt  input  1  synchronous clear of err_count.
REQ-009 z  output  1  running parity (XOR) of the data bits accepted so far in the current frame.
REQ-010 busy  output  1  high while a frame is partially received.
REQ-011 data_out  output  DATA_BITS  data word of the most recently completed frame.
REQ-012 frame_valid  output  1  one-cycle pulse when a frame completes.
REQ-013 parity_err  output  1  parity mismatch flag, valid only while frame_valid=1.
REQ-014 err_count  output  CNT_W  saturating count of frames with a parity error.

Function
REQ-015 The FSM SHALL have two states: DATA (receiving data bits) and PAR (expecting the parity bit).
REQ-016 In DATA, an accepted bit SHALL be written to shift-register position bit_cnt, XORed into acc, and SHALL increment bit_cnt.
REQ-017 When the accepted DATA bit has bit_cnt = DATA_BITS-1, the FSM SHALL move to PAR.
REQ-018 In PAR, an accepted bit SHALL be compared with expected = acc XOR ODD; parity_err SHALL be 1 when x != expected.
REQ-019 On the edge that accepts the parity bit, the block SHALL register data_out and parity_err, set frame_valid for the following cycle only, clear acc and bit_cnt, and return to DATA.
REQ-020 Latency: frame_valid SHALL be high in the cycle immediately after the parity-bit edge; there are no back-to-back stalls, so the next frame's first bit is accepted on the following edge.
REQ-021 While x_valid=0, state, bit_cnt, acc and z SHALL hold; gaps of any length SHALL be allowed anywhere in a frame.
REQ-022 z SHALL equal the registered acc; z SHALL be 0 at the start of every frame.
REQ-023 busy SHALL be 1 when bit_cnt != 0 or the state is PAR; otherwise busy SHALL be 0.
REQ-024 data_out SHALL hold its value until the next frame completes; it SHALL update even when parity_err=1.
REQ-025 parity_err SHALL be 0 whenever frame_valid=0.
REQ-026 err_count SHALL increment by 1 on each completed frame with a parity error and SHALL saturate at 2^CNT_W-1 without wrapping.
REQ-027 clr_cnt=1 SHALL set err_count to 0 on that edge; when a clear and an error occur on the same edge, the clear SHALL win and the result SHALL be 0.
REQ-028 clr_cnt SHALL NOT affect frame reception, data_out or the FSM.

Reset
REQ-029 With rst=1 at a rising edge, the block SHALL load: state DATA, bit_cnt=0, acc=0, z=0, busy=0, data_out=0, frame_valid=0, parity_err=0, err_count=0.
REQ-030 rst SHALL take priority over x_valid and clr_cnt.
REQ-031 A reset mid-frame SHALL discard the partial frame; reception SHALL restart from data bit 0 on the first accepted bit after rst deasserts.

Verification (DATA_BITS=8 unless stated)
REQ-032 ODD=0; send 0xA5 as 1,0,1,0,0,1,0,1, then parity bit 0 -> next cycle frame_valid=1, data_out=0xA5, parity_err=0, err_count=0; z=0 after the eighth bit.
REQ-033 ODD=0; send 0xA5 with parity bit 1 -> frame_valid=1, parity_err=1, err_count=1; data_out=0xA5.
REQ-034 ODD=1; send 0x01 with parity bit 0 -> parity_err=0; repeat with parity bit 1 -> parity_err=1.
REQ-035 Insert random x_valid=0 gaps of 0-5 cycles between bits of 0x3C with correct parity -> result identical to the gap-free run (data_out=0x3C, parity_err=0), and busy=1 throughout the frame.
REQ-036 CNT_W=2; send 5 bad frames -> err_count sequence 1,2,3,3,3; assert clr_cnt on the same edge as a sixth bad parity bit -> err_count=0.
REQ-037 Assert rst after 4 data bits -> busy=0 and z=0; then a full frame 0xFF with parity 0 -> data_out=0xFF, parity_err=0.
